// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and defaults for the TFF counter sequencer.
package tff_count_ctrl_pkg;

  localparam int unsigned DefWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/tff_count_ctrl_cell.sv
// One toggle flip-flop stage: async active-low clear, sync load over toggle.
module tff_count_ctrl_cell (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_ld,
  input  logic i_d,
  input  logic i_t,
  output logic o_q,
  output logic o_qnot
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_q <= 1'b0;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q    = r_q;
  assign o_qnot = ~r_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer turning start/limit/direction commands into per-stage toggle
// enables for a synchronous bank of TFFs; reports busy, done and wrap.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_pause,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap
);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q, w_qnot, w_tog;
  logic [WIDTH-1:0] w_up_ok, w_dn_ok;
  logic             w_load, w_start, w_step, w_wrap_d;

  // Load wins over start when both arrive in IDLE.
  assign w_load  = (r_state == StIdle) && i_load;
  assign w_start = (r_state == StIdle) && !i_load && i_start;

  always_comb begin
    w_state_d = r_state;
    w_step    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_d = StRun;
      end
      StRun: begin
        if (i_stop)                w_state_d = StIdle;
        else if (i_pause)          w_state_d = StPause;
        else if (w_q == r_limit)   w_state_d = StDone;
        else                       w_step    = 1'b1;
      end
      StPause: begin
        if (i_stop)        w_state_d = StIdle;
        else if (!i_pause) w_state_d = StRun;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Stage i toggles when every lower stage is at the carry (up) or borrow (down) value.
  always_comb begin
    w_up_ok[0] = 1'b1;
    w_dn_ok[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_ok[i] = w_up_ok[i-1] & w_q[i-1];
      w_dn_ok[i] = w_dn_ok[i-1] & w_qnot[i-1];
    end
    w_tog    = {WIDTH{w_step}} & (r_dir ? w_up_ok : w_dn_ok);
    w_wrap_d = w_step && (r_dir ? (&w_q) : (&w_qnot));
  end

  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_state <= StIdle;
      r_limit <= '0;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wrap  <= w_wrap_d;
      if (w_start) begin
        r_limit <= i_limit;
        r_dir   <= i_dir;
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    tff_count_ctrl_cell u_cell (
      .i_clk  (i_clk),
      .i_clear(i_clear),
      .i_ld   (w_load),
      .i_d    (i_load_val[gi]),
      .i_t    (w_tog[gi]),
      .o_q    (w_q[gi]),
      .o_qnot (w_qnot[gi])
    );
  end

  assign o_count = w_q;
  assign o_busy  = (r_state == StRun) || (r_state == StPause);
  assign o_done  = (r_state == StDone);
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl with a per-cycle behavioural model.
module tb_tff_count_ctrl;

  localparam int W   = 4;
  localparam int Mod = 16;

  logic         i_clk = 1'b0;
  logic         i_clear = 1'b0;
  logic         i_load = 1'b0;
  logic [W-1:0] i_load_val = '0;
  logic         i_start = 1'b0;
  logic         i_dir = 1'b0;
  logic [W-1:0] i_limit = '0;
  logic         i_pause = 1'b0;
  logic         i_stop = 1'b0;
  logic [W-1:0] o_count;
  logic         o_busy, o_done, o_wrap;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .i_clk     (i_clk),
    .i_clear   (i_clear),
    .i_load    (i_load),
    .i_load_val(i_load_val),
    .i_start   (i_start),
    .i_dir     (i_dir),
    .i_limit   (i_limit),
    .i_pause   (i_pause),
    .i_stop    (i_stop),
    .o_count   (o_count),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_wrap    (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 counting, 2 frozen, 3 finished.
  int m_phase = 0, m_count = 0, m_limit = 0, m_wrap = 0;
  bit m_up = 1'b0;

  always @(negedge i_clear) begin
    m_phase = 0; m_count = 0; m_wrap = 0;
  end

  always @(posedge i_clk) begin
    if (i_clear) begin
      m_wrap = 0;
      case (m_phase)
        0: begin
          if (i_load) m_count = int'(i_load_val);
          else if (i_start) begin
            m_up = i_dir; m_limit = int'(i_limit); m_phase = 1;
          end
        end
        1: begin
          if (i_stop) m_phase = 0;
          else if (i_pause) m_phase = 2;
          else if (m_count == m_limit) m_phase = 3;
          else if (m_up) begin
            m_count = (m_count + 1) % Mod;
            m_wrap  = (m_count == 0);
          end else begin
            m_count = (m_count + Mod - 1) % Mod;
            m_wrap  = (m_count == Mod - 1);
          end
        end
        2: begin
          if (i_stop) m_phase = 0;
          else if (!i_pause) m_phase = 1;
        end
        default: m_phase = 0;
      endcase
    end
    #1;
    if (chk_en) begin
      check("cmp_count", int'(o_count), m_count);
      check("cmp_busy", int'(o_busy), int'(m_phase == 1 || m_phase == 2));
      check("cmp_done", int'(o_done), int'(m_phase == 3));
      check("cmp_wrap", int'(o_wrap), m_wrap);
    end
  end

  task automatic edge_();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_load(input int v);
    i_load = 1'b1; i_load_val = W'(v);
    edge_();
    i_load = 1'b0;
  endtask

  task automatic do_start(input bit up, input int lim);
    i_start = 1'b1; i_dir = up; i_limit = W'(lim);
    edge_();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin edge_(); n++; end
    check("done_reached", int'(o_done), 1);
  endtask

  task automatic run_to(input int target, input int budget);
    int n = 0;
    while (int'(o_count) != target && n < budget) begin edge_(); n++; end
    check("run_to_count", int'(o_count), target);
  endtask

  initial begin
    #12;
    check("reset_count", int'(o_count), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_wrap", int'(o_wrap), 0);
    i_clear = 1'b1;
    chk_en = 1'b1;
    edge_();

    // 1: up 3 -> 7
    do_load(3);
    check("t1_load", int'(o_count), 3);
    do_start(1'b1, 7);
    check("t1_start_count", int'(o_count), 3);
    check("t1_start_busy", int'(o_busy), 1);
    for (int k = 4; k <= 7; k++) begin
      edge_();
      check("t1_step", int'(o_count), k);
      check("t1_busy", int'(o_busy), 1);
    end
    edge_();
    check("t1_done", int'(o_done), 1);
    check("t1_done_busy", int'(o_busy), 0);
    edge_();
    check("t1_done_pulse", int'(o_done), 0);

    // 2: up 14 -> 1 across wrap
    do_load(14);
    do_start(1'b1, 1);
    edge_(); check("t2_c15", int'(o_count), 15);
    edge_(); check("t2_c0", int'(o_count), 0); check("t2_wrap", int'(o_wrap), 1);
    edge_(); check("t2_c1", int'(o_count), 1); check("t2_wrap_off", int'(o_wrap), 0);
    edge_(); check("t2_done", int'(o_done), 1);
    edge_(); check("t2_single_done", int'(o_done), 0);

    // 3: down 2 -> 14 across wrap
    do_load(2);
    do_start(1'b0, 14);
    edge_(); check("t3_c1", int'(o_count), 1);
    edge_(); check("t3_c0", int'(o_count), 0);
    edge_(); check("t3_c15", int'(o_count), 15); check("t3_wrap", int'(o_wrap), 1);
    edge_(); check("t3_c14", int'(o_count), 14);
    edge_(); check("t3_done", int'(o_done), 1);
    edge_();

    // 4: pause at 5, then a stopped run
    do_load(0);
    do_start(1'b1, 9);
    run_to(5, 10);
    i_pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_();
      check("t4_pause_hold", int'(o_count), 5);
      check("t4_pause_busy", int'(o_busy), 1);
    end
    i_pause = 1'b0;
    wait_done(10);
    check("t4_final", int'(o_count), 9);
    edge_();
    do_load(0);
    do_start(1'b1, 9);
    run_to(4, 10);
    i_stop = 1'b1;
    edge_();
    i_stop = 1'b0;
    check("t4_stop_busy", int'(o_busy), 0);
    check("t4_stop_count", int'(o_count), 4);
    edge_(); edge_();
    check("t4_no_done", int'(o_done), 0);

    // 5: async clear mid-run
    do_load(0);
    do_start(1'b1, 9);
    run_to(5, 10);
    #1 i_clear = 1'b0;
    #1;
    check("t5_clear_count", int'(o_count), 0);
    check("t5_clear_busy", int'(o_busy), 0);
    edge_();
    i_clear = 1'b1;
    edge_(); edge_();
    check("t5_idle_busy", int'(o_busy), 0);
    check("t5_idle_count", int'(o_count), 0);
    do_start(1'b1, 2);
    check("t5_restart_busy", int'(o_busy), 1);
    wait_done(10);
    edge_();

    // 6: load+start, immediate done, start while busy
    i_load = 1'b1; i_load_val = 4'd6; i_start = 1'b1; i_dir = 1'b1; i_limit = 4'd9;
    edge_();
    i_load = 1'b0; i_start = 1'b0;
    check("t6_ls_count", int'(o_count), 6);
    check("t6_ls_idle", int'(o_busy), 0);
    edge_();
    check("t6_ls_still_idle", int'(o_busy), 0);
    do_load(8);
    do_start(1'b1, 8);
    check("t6_eq_count", int'(o_count), 8);
    edge_();
    check("t6_eq_done", int'(o_done), 1);
    check("t6_eq_nostep", int'(o_count), 8);
    edge_();
    do_load(0);
    do_start(1'b1, 3);
    i_start = 1'b1; i_dir = 1'b0; i_limit = 4'd0; i_load = 1'b1; i_load_val = 4'd9;
    edge_();
    i_start = 1'b0; i_load = 1'b0;
    check("t6_busy_ignore", int'(o_count), 1);
    wait_done(10);
    check("t6_busy_final", int'(o_count), 3);
    edge_();
    edge_();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
